// File: rtl/lcd_pkg.sv
// Shared LCD character codes, alarm FSM encoding and counter sizing helper
// for the LCD display blocks.
package lcd_pkg;

    localparam logic [7:0] LcdZero  = 8'h30;
    localparam logic [7:0] LcdOne   = 8'h31;
    localparam logic [7:0] LcdTwo   = 8'h32;
    localparam logic [7:0] LcdThree = 8'h33;
    localparam logic [7:0] LcdFour  = 8'h34;
    localparam logic [7:0] LcdFive  = 8'h35;
    localparam logic [7:0] LcdSix   = 8'h36;
    localparam logic [7:0] LcdSeven = 8'h37;
    localparam logic [7:0] LcdEight = 8'h38;
    localparam logic [7:0] LcdNine  = 8'h39;
    localparam logic [7:0] LcdError = 8'h3A;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRing = 2'd1,
        StAck  = 2'd2
    } alarm_state_e;

    // Counter width for a modulus/limit n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_digit_decode.sv
// Combinational BCD nibble to LCD character code; non-BCD nibbles show the
// error glyph.
module lcd_digit_decode
    import lcd_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] char_o
);

    always_comb begin
        char_o = LcdError;
        case (bcd_i)
            4'd0:    char_o = LcdZero;
            4'd1:    char_o = LcdOne;
            4'd2:    char_o = LcdTwo;
            4'd3:    char_o = LcdThree;
            4'd4:    char_o = LcdFour;
            4'd5:    char_o = LcdFive;
            4'd6:    char_o = LcdSix;
            4'd7:    char_o = LcdSeven;
            4'd8:    char_o = LcdEight;
            4'd9:    char_o = LcdNine;
            default: char_o = LcdError;
        endcase
    end

endmodule

// File: rtl/lcd_scan_driver.sv
// Multiplexed multi-digit LCD scan driver with a sequenced alarm
// (ring, beep pattern, acknowledge and timeout).
module lcd_scan_driver
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 4,
    parameter int unsigned BEEP_DIV   = 8,
    parameter int unsigned RING_BEEPS = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] alarm_time,
    input  logic [4*NUM_DIGITS-1:0] current_time,
    input  logic [4*NUM_DIGITS-1:0] key_time,
    input  logic                    show_alarm,
    input  logic                    show_new_time,
    input  logic                    alarm_enable,
    input  logic                    stop_alarm,
    output logic [7:0]              display_time,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    sound_alarm,
    output logic                    alarm_active
);

    localparam int unsigned ScanW  = cnt_width(SCAN_DIV);
    localparam int unsigned DigitW = cnt_width(NUM_DIGITS);
    localparam int unsigned BeepW  = cnt_width(BEEP_DIV);
    localparam int unsigned HalfW  = cnt_width(RING_BEEPS);

    localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
    localparam logic [DigitW-1:0] DigitLast = DigitW'(NUM_DIGITS - 1);
    localparam logic [BeepW-1:0]  BeepLast  = BeepW'(BEEP_DIV - 1);
    localparam logic [HalfW-1:0]  HalfLast  = HalfW'(RING_BEEPS - 1);

    // ---------------------------------------------------------------- source mux
    logic [4*NUM_DIGITS-1:0] src_time;

    always_comb begin
        if (show_alarm) begin
            src_time = alarm_time;
        end else if (show_new_time) begin
            src_time = key_time;
        end else begin
            src_time = current_time;
        end
    end

    // ---------------------------------------------------------------- scan
    logic [ScanW-1:0]      scan_cnt_q, scan_cnt_d;
    logic [DigitW-1:0]     digit_idx_q, digit_idx_d;
    logic [7:0]            display_q;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [3:0]            nibble_d;
    logic [7:0]            char_d;
    logic                  scan_tick;

    always_comb begin
        scan_tick   = (scan_cnt_q == ScanLast);
        scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (scan_tick) begin
            digit_idx_d = (digit_idx_q == DigitLast) ? '0 : digit_idx_q + 1'b1;
        end
        nibble_d    = 4'd0;
        digit_sel_d = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (digit_idx_d == DigitW'(i)) begin
                nibble_d       = src_time[i*4 +: 4];
                digit_sel_d[i] = 1'b1;
            end
        end
    end

    lcd_digit_decode u_decode (
        .bcd_i  (nibble_d),
        .char_o (char_d)
    );

    // Outputs only reload on a tick, so mid-slot source changes never glitch.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            display_q   <= LcdZero;
            digit_sel_q <= NUM_DIGITS'(1);
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            if (scan_tick) begin
                display_q   <= char_d;
                digit_sel_q <= digit_sel_d;
            end
        end
    end

    assign display_time = display_q;
    assign digit_sel    = digit_sel_q;

    // ---------------------------------------------------------------- alarm FSM
    alarm_state_e     state_q, state_d;
    logic [BeepW-1:0] beep_cnt_q, beep_cnt_d;
    logic [HalfW-1:0] half_cnt_q, half_cnt_d;
    logic             sound_q, sound_d;
    logic             match;
    logic             beep_tick;
    logic             ring_timeout;

    assign match = (current_time == alarm_time);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beep_cnt_q <= '0;
            half_cnt_q <= '0;
            sound_q    <= 1'b0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            half_cnt_q <= half_cnt_d;
            sound_q    <= sound_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beep_cnt_d   = beep_cnt_q;
        half_cnt_d   = half_cnt_q;
        sound_d      = 1'b0;
        beep_tick    = (beep_cnt_q == BeepLast);
        ring_timeout = beep_tick && (half_cnt_q == HalfLast);

        if (!alarm_enable) begin
            state_d    = StIdle;
            beep_cnt_d = '0;
            half_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (match) begin
                        // A stop arriving with the match skips ringing entirely.
                        state_d    = stop_alarm ? StAck : StRing;
                        beep_cnt_d = '0;
                        half_cnt_d = '0;
                        sound_d    = !stop_alarm;
                    end
                end
                StRing: begin
                    if (stop_alarm || ring_timeout) begin
                        state_d = StAck;
                    end else begin
                        sound_d    = beep_tick ? !sound_q : sound_q;
                        beep_cnt_d = beep_tick ? '0 : beep_cnt_q + 1'b1;
                        half_cnt_d = beep_tick ? half_cnt_q + 1'b1 : half_cnt_q;
                    end
                end
                StAck: begin
                    if (!match) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        alarm_active = (state_q == StRing);
        sound_alarm  = sound_q && (state_q == StRing);
    end

endmodule
